// File: rtl/fft_bitrev_buffer.sv
// fft_bitrev_buffer
// Input stage of the FFT core. Serial samples arrive over valid/ready and are
// written into one half of a ping-pong frame buffer at their bit-reversed (or
// natural) address. A completed half is shown to the butterfly array as one
// flat word while the other half fills. Frame-length mismatches pulse
// frame_err. All state changes on the falling edge of clk; rst is active low.
module fft_bitrev_buffer #(
    parameter int N_POINTS = 64,
    parameter int LOG2_N   = 6,
    parameter int DATA_W   = 16,
    parameter int BITREV   = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_W-1:0]            in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_last,
    output logic [N_POINTS*DATA_W-1:0]   out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         frame_err
);

    localparam logic [LOG2_N-1:0] LAST_IDX = LOG2_N'(N_POINTS - 1);

    // Mirror the LOG2_N address bits: bit i of the result is bit LOG2_N-1-i.
    function automatic logic [LOG2_N-1:0] bit_reverse(input logic [LOG2_N-1:0] idx);
        logic [LOG2_N-1:0] rev;
        rev = '0;
        for (int i = 0; i < LOG2_N; i++) begin
            rev[i] = idx[LOG2_N-1-i];
        end
        return rev;
    endfunction

    // Two frame banks; bank index is wr_bank / rd_bank.
    logic [DATA_W-1:0] bank_mem [2][N_POINTS];

    logic [1:0]        full;
    logic [1:0]        full_nxt;
    logic              wr_bank;
    logic              rd_bank;
    logic [LOG2_N-1:0] wr_cnt;
    logic [LOG2_N-1:0] wr_addr;

    logic accept;
    logic xfer;
    logic cnt_at_end;
    logic frame_done;
    logic frame_abort;
    logic len_err;

    // Handshake qualifiers. in_ready is held low while rst is asserted so the
    // source cannot see a ready before the buffer is out of reset; otherwise it
    // depends only on registered state, never on in_valid.
    assign in_ready    = rst & ~full[wr_bank];
    assign out_valid   = full[rd_bank];
    assign accept      = in_valid & in_ready;
    assign xfer        = out_valid & out_ready;

    // Frame boundary decode. A frame ends on the N-th sample regardless of
    // in_last; in_last anywhere else aborts the frame. Either disagreement
    // between counter and in_last is a length error.
    assign cnt_at_end  = (wr_cnt == LAST_IDX);
    assign frame_done  = accept & cnt_at_end;
    assign frame_abort = accept & in_last & ~cnt_at_end;
    assign len_err     = accept & (cnt_at_end ^ in_last);

    // Write address: reversed or natural order, fixed at elaboration.
    generate
        if (BITREV != 0) begin : g_rev_addr
            assign wr_addr = bit_reverse(wr_cnt);
        end else begin : g_nat_addr
            assign wr_addr = wr_cnt;
        end
    endgenerate

    // Read bank flattened onto the output bus, slot k at bits [k*DATA_W +: DATA_W].
    generate
        for (genvar k = 0; k < N_POINTS; k++) begin : g_slot
            assign out_data[k*DATA_W +: DATA_W] = bank_mem[rd_bank][k];
        end
    endgenerate

    // Next full flags: a completion and a transfer on the same edge always hit
    // different banks (accept needs the write bank empty, transfer needs the
    // read bank full), so applying both is safe.
    always_comb begin
        full_nxt = full;
        if (xfer) begin
            full_nxt[rd_bank] = 1'b0;
        end
        if (frame_done) begin
            full_nxt[wr_bank] = 1'b1;
        end
    end

    // Sample storage; cleared on reset so no stale frame can leak out.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < N_POINTS; i++) begin
                    bank_mem[b][i] <= '0;
                end
            end
        end else if (accept) begin
            bank_mem[wr_bank][wr_addr] <= in_data;
        end
    end

    // Write counter and write-bank pointer.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            wr_cnt  <= '0;
            wr_bank <= 1'b0;
        end else if (frame_done) begin
            wr_cnt  <= '0;
            wr_bank <= ~wr_bank;
        end else if (frame_abort) begin
            wr_cnt  <= '0;
        end else if (accept) begin
            wr_cnt  <= wr_cnt + 1'b1;
        end
    end

    // Bank occupancy flags.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            full <= 2'b00;
        end else begin
            full <= full_nxt;
        end
    end

    // Read-bank pointer advances on every frame handed to the consumer.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            rd_bank <= 1'b0;
        end else if (xfer) begin
            rd_bank <= ~rd_bank;
        end
    end

    // One-cycle length-error pulse.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            frame_err <= 1'b0;
        end else begin
            frame_err <= len_err;
        end
    end

endmodule

// File: tb/tb_fft_bitrev_buffer.sv
// Bench for fft_bitrev_buffer: a 64-point bit-reversed instance driven through
// a frame scoreboard, plus an 8-point natural-order instance exercised by hand.
module tb_fft_bitrev_buffer;

    localparam int NA = 64;
    localparam int LA = 6;
    localparam int WA = 16;
    localparam int NB = 8;
    localparam int LB = 3;
    localparam int WB = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic [WA-1:0]    a_in_data;
    logic             a_in_valid, a_in_ready, a_in_last;
    logic [NA*WA-1:0] a_out_data;
    logic             a_out_valid, a_out_ready, a_frame_err;

    logic [WB-1:0]    b_in_data;
    logic             b_in_valid, b_in_ready, b_in_last;
    logic [NB*WB-1:0] b_out_data;
    logic             b_out_valid, b_out_ready, b_frame_err;

    fft_bitrev_buffer #(.N_POINTS(NA), .LOG2_N(LA), .DATA_W(WA), .BITREV(1)) dut_a (
        .clk(clk), .rst(rst),
        .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_last(a_in_last),
        .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .frame_err(a_frame_err)
    );

    fft_bitrev_buffer #(.N_POINTS(NB), .LOG2_N(LB), .DATA_W(WB), .BITREV(0)) dut_b (
        .clk(clk), .rst(rst),
        .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_last(b_in_last),
        .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .frame_err(b_frame_err)
    );

    typedef struct {
        int tst;
        int slot;
        int val;
    } vec_t;

    vec_t vecs[10];

    int n_pass  = 0;
    int n_total = 0;

    logic [NA*WA-1:0] sb_q[$];
    logic [NA*WA-1:0] m_cur;
    int               m_cnt;
    logic             m_err;
    logic             m_acc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic check_frame(input string name, input logic [NA*WA-1:0] act,
                               input logic [NA*WA-1:0] exp);
        int k;
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            k = 0;
            while (k < NA - 1 && act[k*WA +: WA] === exp[k*WA +: WA]) k++;
            $display("FAIL %s slot %0d: got %0h expected %0h", name, k,
                     act[k*WA +: WA], exp[k*WA +: WA]);
        end
    endtask

    function automatic int brev(input int n);
        int r;
        r = 0;
        for (int i = 0; i < LA; i++) begin
            if (n[i]) r = r | (1 << (LA - 1 - i));
        end
        return r;
    endfunction

    task automatic model_reset();
        sb_q.delete();
        m_cur = '0;
        m_cnt = 0;
        m_err = 1'b0;
        m_acc = 1'b0;
    endtask

    // One clock of dut_a: check outputs against the model, take the edge,
    // then advance the model and check frame_err.
    task automatic cyc();
        logic exp_ready;
        logic exp_xfer;
        exp_ready = (sb_q.size() < 2);
        check("in_ready", 64'(a_in_ready), 64'(exp_ready));
        check("out_valid", 64'(a_out_valid), 64'(sb_q.size() > 0));
        if (sb_q.size() > 0) check_frame("out_data", a_out_data, sb_q[0]);
        exp_xfer = (sb_q.size() > 0) && a_out_ready;
        m_acc    = a_in_valid && exp_ready;
        m_err    = 1'b0;
        @(negedge clk);
        #1;
        if (exp_xfer) sb_q.delete(0);
        if (m_acc) begin
            m_cur[brev(m_cnt)*WA +: WA] = a_in_data;
            if (m_cnt == NA - 1) begin
                sb_q.push_back(m_cur);
                m_err = !a_in_last;
                m_cnt = 0;
            end else if (a_in_last) begin
                m_err = 1'b1;
                m_cnt = 0;
            end else begin
                m_cnt++;
            end
        end
        check("frame_err", 64'(a_frame_err), 64'(m_err));
    endtask

    task automatic send(input int d, input logic last);
        a_in_valid = 1'b1;
        a_in_data  = WA'(d);
        a_in_last  = last;
        for (int t = 0; t < 50; t++) begin
            cyc();
            if (m_acc) break;
        end
        if (!m_acc) begin
            n_total++;
            $display("FAIL send_timeout: sample %0h not accepted within 50 cycles", d);
        end
        a_in_valid = 1'b0;
        a_in_last  = 1'b0;
    endtask

    task automatic send_frame(input int base, input int n, input logic last_on_end);
        for (int i = 0; i < n; i++) begin
            send(base + i, (i == n - 1) && last_on_end);
        end
    endtask

    task automatic check_slots(input int tst);
        for (int v = 0; v < 10; v++) begin
            if (vecs[v].tst == tst) begin
                if (tst == 6)
                    check($sformatf("t%0d_slot%0d", tst, vecs[v].slot),
                          64'(b_out_data[vecs[v].slot*WB +: WB]), 64'(vecs[v].val));
                else
                    check($sformatf("t%0d_slot%0d", tst, vecs[v].slot),
                          64'(a_out_data[vecs[v].slot*WA +: WA]), 64'(vecs[v].val));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1, 0, 0};
        vecs[1] = '{1, 1, 32};
        vecs[2] = '{1, 2, 16};
        vecs[3] = '{1, 3, 48};
        vecs[4] = '{1, 63, 63};
        vecs[5] = '{3, 0, 100};
        vecs[6] = '{3, 1, 132};
        vecs[7] = '{6, 0, 'h10};
        vecs[8] = '{6, 3, 'h13};
        vecs[9] = '{6, 7, 'h17};

        a_in_data = '0; a_in_valid = 1'b0; a_in_last = 1'b0; a_out_ready = 1'b0;
        b_in_data = '0; b_in_valid = 1'b0; b_in_last = 1'b0; b_out_ready = 1'b0;
        model_reset();

        // Reset state
        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        check("rst_in_ready", 64'(a_in_ready), 64'(0));
        check("rst_out_valid", 64'(a_out_valid), 64'(0));
        check_frame("rst_out_data", a_out_data, '0);
        repeat (2) @(posedge clk);
        rst = 1'b1;
        #1;
        check("rel_in_ready", 64'(a_in_ready), 64'(1));
        check("rel_b_in_ready", 64'(b_in_ready), 64'(1));
        @(negedge clk);
        #1;

        // 1: bit-reversed frame, consumer always ready
        a_out_ready = 1'b1;
        send_frame(0, 64, 1'b1);
        check("t1_valid", 64'(a_out_valid), 64'(1));
        check_slots(1);
        cyc();

        // 2: both banks fill, stream stalls, one transfer frees a bank
        a_out_ready = 1'b0;
        send_frame(1000, 64, 1'b1);
        send_frame(2000, 64, 1'b1);
        check("t2_stall_ready", 64'(a_in_ready), 64'(0));
        a_in_valid = 1'b1; a_in_data = WA'(3000); a_in_last = 1'b0;
        repeat (3) cyc();
        a_out_ready = 1'b1;
        cyc();
        a_out_ready = 1'b0;
        check("t2_ready_after", 64'(a_in_ready), 64'(1));
        check("t2_frame2_slot0", 64'(a_out_data[0 +: WA]), 64'(2000));
        send_frame(3000, 64, 1'b1);
        a_out_ready = 1'b1;
        repeat (3) cyc();
        check("t2_drained", 64'(a_out_valid), 64'(0));

        // in_last without in_valid is ignored
        a_in_last = 1'b1;
        cyc();
        a_in_last = 1'b0;

        // 3: early in_last aborts the frame
        send_frame(500, 11, 1'b1);
        check("t3_err_pulse", 64'(a_frame_err), 64'(1));
        cyc();
        check("t3_err_cleared", 64'(a_frame_err), 64'(0));
        check("t3_no_valid", 64'(a_out_valid), 64'(0));
        send_frame(100, 64, 1'b1);
        check_slots(3);
        cyc();

        // 5: completion of B coincides with transfer of held A
        a_out_ready = 1'b0;
        send_frame(4000, 64, 1'b1);
        send_frame(5000, 63, 1'b0);
        a_out_ready = 1'b1;
        send(5063, 1'b1);
        a_out_ready = 1'b0;
        check("t5_valid", 64'(a_out_valid), 64'(1));
        check("t5_slot0", 64'(a_out_data[0 +: WA]), 64'(5000));
        check("t5_slot1", 64'(a_out_data[1*WA +: WA]), 64'(5032));
        check("t5_ready", 64'(a_in_ready), 64'(1));
        a_out_ready = 1'b1;
        repeat (2) cyc();

        // 4: reset mid-frame with a frame held
        a_out_ready = 1'b0;
        send_frame(6000, 64, 1'b1);
        send_frame(7000, 30, 1'b0);
        #2 rst = 1'b0;
        #1;
        check("t4_out_valid", 64'(a_out_valid), 64'(0));
        check_frame("t4_out_data", a_out_data, '0);
        check("t4_in_ready", 64'(a_in_ready), 64'(0));
        model_reset();
        @(posedge clk);
        rst = 1'b1;
        #1;
        check("t4_rel_ready", 64'(a_in_ready), 64'(1));
        @(negedge clk);
        #1;
        a_out_ready = 1'b1;
        send_frame(8000, 64, 1'b1);
        check("t4_slot0", 64'(a_out_data[0 +: WA]), 64'(8000));
        check("t4_slot1", 64'(a_out_data[1*WA +: WA]), 64'(8032));
        cyc();

        // 6: natural order, 8 points, final sample without in_last
        for (int i = 0; i < NB; i++) begin
            b_in_valid = 1'b1;
            b_in_data  = WB'(16 + i);
            b_in_last  = 1'b0;
            check($sformatf("t6_ready%0d", i), 64'(b_in_ready), 64'(1));
            @(negedge clk);
            #1;
            if (i < NB - 1) check($sformatf("t6_noerr%0d", i), 64'(b_frame_err), 64'(0));
        end
        b_in_valid = 1'b0;
        check("t6_err", 64'(b_frame_err), 64'(1));
        check("t6_valid", 64'(b_out_valid), 64'(1));
        check_slots(6);
        @(negedge clk);
        #1;
        check("t6_err_cleared", 64'(b_frame_err), 64'(0));
        check("t6_hold", 64'(b_out_valid), 64'(1));
        check("t6_hold_slot7", 64'(b_out_data[7*WB +: WB]), 64'('h17));
        b_out_ready = 1'b1;
        @(negedge clk);
        #1;
        check("t6_taken", 64'(b_out_valid), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fft_bitrev_buffer.md
Name: fft_bitrev_buffer

Overview:
Parametrised input stage for the FFT core. Accepts a serial stream of DATA_W-bit samples over a valid/ready handshake and writes each sample into a ping-pong frame buffer at its bit-reversed (or natural) address. Completed frames are presented as one flat parallel word to the butterfly array. Supersedes the plain per-sample register bank by adding reordering, double buffering, backpressure and frame-error detection.

Parameters:
N_POINTS, 64, samples per frame; must be a power of two, at least 4.
LOG2_N, 6, log2(N_POINTS); sets the width of the write counter.
DATA_W, 16, bits per sample.
BITREV, 1, 1 = store sample n at address bitrev(n); 0 = store at address n.

Ports:
clk  in  1  clock; all state updates on the falling edge.
rst  in  1  asynchronous active-low reset.
in_data  in  DATA_W  sample value.
in_valid  in  1  in_data is valid this cycle.
in_ready  out  1  buffer can accept a sample.
in_last  in  1  marks the final sample of a frame; qualified by in_valid.
out_data  out  N_POINTS*DATA_W  read-bank contents; slot k at bits [k*DATA_W +: DATA_W].
out_valid  out  1  read bank holds a complete frame.
out_ready  in  1  consumer takes the frame.
frame_err  out  1  one-cycle pulse on a frame-length mismatch.

Behaviour:
- Reset (rst low, asynchronous): both banks cleared to 0; full[1:0]=0; wr_bank=0; rd_bank=0; wr_cnt=0; frame_err=0. While rst is low, out_valid=0, out_data=0 and in_ready=0. in_ready is 1 from the first cycle after release.
- Sample accept: in_valid && in_ready at a falling edge. The sample is written to bank[wr_bank][addr]. addr = bitrev(wr_cnt) when BITREV=1 (reverse the LOG2_N bits), otherwise addr = wr_cnt. wr_cnt then increments.
- in_ready = !full[wr_bank]. It is combinational from registered state, with no dependence on in_valid.
- Frame complete: an accept with wr_cnt == N_POINTS-1. Sets full[wr_bank]=1, toggles wr_bank and sets wr_cnt=0.
  - If in_last=0 on this sample, the frame is still completed and frame_err pulses.
- Early last: an accept with in_last=1 and wr_cnt < N_POINTS-1. The sample is written, wr_cnt is forced to 0, the bank is not marked full, and frame_err pulses for one cycle. The partial frame is discarded; stale bank data is overwritten by the next frame.
- Output side: out_valid = full[rd_bank], and out_data = bank[rd_bank].
  - Transfer occurs on out_valid && out_ready at a falling edge. It clears full[rd_bank] and toggles rd_bank.
  - out_data is held stable while out_valid=1 and out_ready=0.
- Latency: the last sample is accepted at edge k, and out_valid=1 from edge k with the full frame on out_data. When the read bank is empty, there is zero added latency beyond the write.
- Both banks full: in_ready=0 and the stream stalls. The first transfer frees a bank, and in_ready=1 right after that edge.
- Simultaneous frame completion and transfer on the same edge: both take effect. With one bank full before the edge, out_valid stays 1 and out_data switches to the new frame. No frame is lost or duplicated.
- in_last with in_valid=0 is ignored.
- Reset mid-frame or mid-hold discards all buffered data. There is no partial output, and the next accepted sample is sample 0 of a new frame.
- No arithmetic on data; values pass through bit-exact.

Test Plan:
1. N=64, BITREV=1, out_ready=1, stream values 0..63 with in_last on 63 -> out_valid=1 at the edge of sample 63; slot0=0, slot1=32, slot2=16, slot3=48, slot63=63; frame_err stays 0.
2. out_ready=0, stream 128 samples (two frames) then start a third -> in_ready=0 after sample 128, third stream stalls; one out_ready pulse -> frame 1 out, out_data shows frame 2, in_ready=1 next cycle, third frame proceeds.
3. in_last on sample index 10 -> frame_err=1 for exactly one cycle, out_valid stays 0; the next 64 samples 100..163 give slot0=100, slot1=132.
4. Reset asserted after 30 samples of a frame with a prior frame held -> out_valid=0, out_data=0 immediately; after release in_ready=1, and a fresh 64-sample frame appears correctly aligned.
5. Frame A held, last sample of frame B coincides with the out_ready transfer of A -> out_valid stays 1, out_data = frame B next cycle, in_ready never drops.
6. BITREV=0, N=8, DATA_W=8, stream 0x10..0x17 -> slot k = 0x10+k; sample 7 sent with in_last=0 -> frame completes and frame_err pulses.
